// File: rtl/nurn_update_seq_if.sv
// Bus bundle for the neuron update sequencer: sweep handshake, status-memory
// read port A, status-memory write port B and the spike event output.
interface nurn_update_seq_if #(
   parameter int DSIZE              = 16,
   parameter int NURN_CNT_BIT_WIDTH = 8
);
   logic                            start_i;
   logic                            busy_o;
   logic                            done_o;
   logic [NURN_CNT_BIT_WIDTH+1:0]   Addr_StatRd_A_o;
   logic                            rdEn_StatRd_A_o;
   logic [DSIZE-1:0]                data_StatRd_A_i;
   logic [NURN_CNT_BIT_WIDTH+1:0]   Addr_StatWr_B_o;
   logic                            wrEn_StatWr_B_o;
   logic [DSIZE-1:0]                data_StatWr_B_o;
   logic                            spike_o;
   logic [NURN_CNT_BIT_WIDTH-1:0]   spikeNurnId_o;

   modport master (
      input  start_i, data_StatRd_A_i,
      output busy_o, done_o,
      output Addr_StatRd_A_o, rdEn_StatRd_A_o,
      output Addr_StatWr_B_o, wrEn_StatWr_B_o, data_StatWr_B_o,
      output spike_o, spikeNurnId_o
   );

   modport slave (
      output start_i, data_StatRd_A_i,
      input  busy_o, done_o,
      input  Addr_StatRd_A_o, rdEn_StatRd_A_o,
      input  Addr_StatWr_B_o, wrEn_StatWr_B_o, data_StatWr_B_o,
      input  spike_o, spikeNurnId_o
   );
endinterface

// File: rtl/nurn_update_seq.sv
// Sweeps every neuron once per start: reads bias/potential/threshold, integrates
// with saturation, writes back the potential and clears post-spike history on fire.
module nurn_update_seq #(
   parameter int NUM_NURNS          = 256,
   parameter int DSIZE              = 16,
   parameter int NURN_CNT_BIT_WIDTH = 8,
   parameter int STDP_WIN_BIT_WIDTH = 8
) (
   input logic                clk_i,
   input logic                rst_n_i,
   nurn_update_seq_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE, RD_BIAS, RD_POT, RD_TH, CALC, WR_POT, WR_HIST
   } state_t;

   localparam logic [NURN_CNT_BIT_WIDTH-1:0] LAST_NURN  = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);
   localparam logic [DSIZE-1:0]              SAT_MAX    = {1'b0, {(DSIZE-1){1'b1}}};
   localparam logic [DSIZE-1:0]              SAT_MIN    = {1'b1, {(DSIZE-1){1'b0}}};
   localparam logic [STDP_WIN_BIT_WIDTH-1:0] HIST_CLEAR = '0;

   state_t                         state, nextState;
   logic [NURN_CNT_BIT_WIDTH-1:0]  nurnCnt;
   logic [DSIZE-1:0]               bias, pot, newPot, sumSat;
   logic [DSIZE:0]                 sumWide;
   logic                           fire, fireNext, lastNurn, doneQ;

   assign lastNurn = (nurnCnt == LAST_NURN);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (bus.start_i) nextState = RD_BIAS;
         RD_BIAS: nextState = RD_POT;
         RD_POT:  nextState = RD_TH;
         RD_TH:   nextState = CALC;
         CALC:    nextState = WR_POT;
         WR_POT:  nextState = fire ? WR_HIST : (lastNurn ? IDLE : RD_BIAS);
         WR_HIST: nextState = lastNurn ? IDLE : RD_BIAS;
         default: nextState = IDLE;
      endcase
   end

   // Two's-complement add one bit wider; a sign disagreement between the top
   // two bits means overflow, and the top bit tells which rail to clamp to.
   always_comb begin
      sumWide = {pot[DSIZE-1], pot} + {bias[DSIZE-1], bias};
      if (sumWide[DSIZE] != sumWide[DSIZE-1]) sumSat = sumWide[DSIZE] ? SAT_MIN : SAT_MAX;
      else                                    sumSat = sumWide[DSIZE-1:0];
      fireNext = ($signed(sumSat) >= $signed(bus.data_StatRd_A_i));
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         nurnCnt <= '0;
         bias    <= '0;
         pot     <= '0;
         newPot  <= '0;
         fire    <= 1'b0;
         doneQ   <= 1'b0;
      end else begin
         doneQ <= (state != IDLE) && (nextState == IDLE);
         unique case (state)
            IDLE:    if (bus.start_i) nurnCnt <= '0;
            RD_POT:  bias <= bus.data_StatRd_A_i;
            RD_TH:   pot  <= bus.data_StatRd_A_i;
            CALC: begin
               fire   <= fireNext;
               newPot <= fireNext ? '0 : sumSat;
            end
            WR_POT:  if (!fire && !lastNurn) nurnCnt <= nurnCnt + 1'b1;
            WR_HIST: if (!lastNurn) nurnCnt <= nurnCnt + 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no latch is inferred;
   // the defaults also keep the buses parked at {n,00}/0 while idle.
   always_comb begin
      bus.busy_o          = (state != IDLE);
      bus.done_o          = doneQ;
      bus.rdEn_StatRd_A_o = 1'b0;
      bus.Addr_StatRd_A_o = {nurnCnt, 2'b00};
      bus.wrEn_StatWr_B_o = 1'b0;
      bus.Addr_StatWr_B_o = {nurnCnt, 2'b00};
      bus.data_StatWr_B_o = '0;
      bus.spike_o         = 1'b0;
      bus.spikeNurnId_o   = '0;
      unique case (state)
         RD_BIAS: bus.rdEn_StatRd_A_o = 1'b1;
         RD_POT: begin
            bus.rdEn_StatRd_A_o      = 1'b1;
            bus.Addr_StatRd_A_o[1:0] = 2'b01;
         end
         RD_TH: begin
            bus.rdEn_StatRd_A_o      = 1'b1;
            bus.Addr_StatRd_A_o[1:0] = 2'b10;
         end
         WR_POT: begin
            bus.wrEn_StatWr_B_o      = 1'b1;
            bus.Addr_StatWr_B_o[1:0] = 2'b01;
            bus.data_StatWr_B_o      = newPot;
         end
         WR_HIST: begin
            bus.wrEn_StatWr_B_o      = 1'b1;
            bus.Addr_StatWr_B_o[1:0] = 2'b11;
            bus.data_StatWr_B_o      = DSIZE'(HIST_CLEAR);
            bus.spike_o              = 1'b1;
            bus.spikeNurnId_o        = nurnCnt;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nurn_update_seq.sv
// Bench for nurn_update_seq: registered status memory, per-sweep expected cycle
// schedule built from the integrate-and-fire rules, and a per-cycle comparator.
module tb_nurn_update_seq;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int NW = 8;
   localparam int AW = NW + 2;
   localparam int MS = 1 << AW;
   localparam int L  = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nurn_update_seq_if #(.DSIZE(DW), .NURN_CNT_BIT_WIDTH(NW)) bus ();

   nurn_update_seq #(
      .NUM_NURNS(N), .DSIZE(DW), .NURN_CNT_BIT_WIDTH(NW), .STDP_WIN_BIT_WIDTH(8)
   ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus)
   );

   // Status memory with one-cycle registered read.
   logic [DW-1:0] mem   [MS];
   logic [DW-1:0] stage [MS];
   logic [DW-1:0] rdData;
   logic          loadMem = 1'b0;

   always @(posedge clk) begin
      if (loadMem) mem <= stage;
      else begin
         if (bus.rdEn_StatRd_A_o) rdData <= mem[bus.Addr_StatRd_A_o];
         if (bus.wrEn_StatWr_B_o) mem[bus.Addr_StatWr_B_o] <= bus.data_StatWr_B_o;
      end
   end
   assign bus.data_StatRd_A_i = rdData;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected per-cycle schedule, indexed by cycles since the start cycle.
   bit            eRd [L], eWr [L], eSp [L], eBusy [L], eDone [L];
   logic [AW-1:0] eRdA [L], eWrA [L];
   logic [DW-1:0] eWrD [L];
   logic [NW-1:0] eId [L];
   logic [DW-1:0] expMem [MS];
   int            doneAt = 0;
   int            off    = 0;
   bit            active = 1'b0;

   function automatic logic [DW-1:0] satAdd(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return s[DW-1:0];
   endfunction

   task automatic buildModel(input bit doneNow);
      int base;
      base = 0;
      for (int k = 0; k < L; k++) begin
         eRd[k] = 0; eWr[k] = 0; eSp[k] = 0; eBusy[k] = 0; eDone[k] = 0;
         eRdA[k] = '0; eWrA[k] = '0; eWrD[k] = '0; eId[k] = '0;
      end
      expMem = mem;
      for (int i = 0; i < N; i++) begin
         logic [DW-1:0] s;
         bit f;
         s = satAdd(mem[i*4+1], mem[i*4+0]);
         f = int'($signed(s)) >= int'($signed(mem[i*4+2]));
         for (int r = 0; r < 3; r++) begin
            eRd[base+1+r]  = 1;
            eRdA[base+1+r] = AW'(i*4 + r);
         end
         eWr[base+5]  = 1;
         eWrA[base+5] = AW'(i*4 + 1);
         eWrD[base+5] = f ? '0 : s;
         expMem[i*4+1] = f ? '0 : s;
         if (f) begin
            eWr[base+6]  = 1;
            eWrA[base+6] = AW'(i*4 + 3);
            eWrD[base+6] = '0;
            eSp[base+6]  = 1;
            eId[base+6]  = NW'(i);
            expMem[i*4+3] = '0;
            base += 6;
         end else begin
            base += 5;
         end
      end
      for (int k = 1; k <= base; k++) eBusy[k] = 1;
      doneAt       = base + 1;
      eDone[doneAt] = 1;
      eDone[0]     = doneNow;
      off          = 0;
      active       = 1;
   endtask

   // Per-cycle comparator plus protocol watch.
   int            doneCount = 0, spikeCount = 0, doneOff = -1;
   logic [NW-1:0] lastSpikeId = '0;
   bit            prvRd = 0, prvIdle = 0;
   logic [1:0]    prvSel = '0;
   logic [NW-1:0] prvN = '0;
   logic [35:0]   idleBus = '0;

   always @(negedge clk) begin
      check("rd_wr_exclusive", 64'(bus.rdEn_StatRd_A_o & bus.wrEn_StatWr_B_o), 64'(0));
      if (bus.spike_o)
         check("spike_in_wr_hist",
               64'({bus.wrEn_StatWr_B_o, bus.Addr_StatWr_B_o[1:0], bus.Addr_StatWr_B_o[AW-1:2]}),
               64'({1'b1, 2'b11, bus.spikeNurnId_o}));
      if (bus.rdEn_StatRd_A_o)
         check("rd_sel_order", 64'(bus.Addr_StatRd_A_o),
               prvRd ? 64'({prvN, prvSel + 2'd1}) : 64'({bus.Addr_StatRd_A_o[AW-1:2], 2'b00}));
      prvRd  = bus.rdEn_StatRd_A_o;
      prvSel = bus.Addr_StatRd_A_o[1:0];
      prvN   = bus.Addr_StatRd_A_o[AW-1:2];
      if (bus.done_o)  doneCount++;
      if (bus.spike_o) begin spikeCount++; lastSpikeId = bus.spikeNurnId_o; end

      if (active) begin
         prvIdle = 0;
         if (bus.done_o) doneOff = off;
         check("ctl busy/done/rd/wr/spike",
               64'({bus.busy_o, bus.done_o, bus.rdEn_StatRd_A_o, bus.wrEn_StatWr_B_o, bus.spike_o}),
               64'({eBusy[off], eDone[off], eRd[off], eWr[off], eSp[off]}));
         if (eRd[off]) check("rd_addr", 64'(bus.Addr_StatRd_A_o), 64'(eRdA[off]));
         if (eWr[off]) check("wr_addr_data", 64'({bus.Addr_StatWr_B_o, bus.data_StatWr_B_o}),
                             64'({eWrA[off], eWrD[off]}));
         if (eSp[off]) check("spike_id", 64'(bus.spikeNurnId_o), 64'(eId[off]));
         if (off == doneAt) active = 0;
         off++;
      end else begin
         check("idle_ctl",
               64'({bus.busy_o, bus.done_o, bus.rdEn_StatRd_A_o, bus.wrEn_StatWr_B_o, bus.spike_o}),
               64'(0));
         if (!rst_n)
            check("reset_bus", 64'({bus.Addr_StatRd_A_o, bus.Addr_StatWr_B_o,
                                    bus.data_StatWr_B_o, bus.spikeNurnId_o}), 64'(0));
         else if (prvIdle)
            check("idle_stable", 64'({bus.Addr_StatRd_A_o, bus.Addr_StatWr_B_o, bus.data_StatWr_B_o}),
                  64'(idleBus));
         prvIdle = rst_n;
         idleBus = {bus.Addr_StatRd_A_o, bus.Addr_StatWr_B_o, bus.data_StatWr_B_o};
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic loadStage();
      loadMem = 1'b1;
      tick(1);
      loadMem = 1'b0;
   endtask

   task automatic launch(input bit doneNow);
      bus.start_i = 1'b1;
      buildModel(doneNow);
      tick(1);
      bus.start_i = 1'b0;
   endtask

   task automatic settleAndCheckMem();
      tick(3);
      for (int i = 0; i < 4*N; i++) check("mem_word", 64'(mem[i]), 64'(expMem[i]));
   endtask

   task automatic setNurn(input int i, input logic [DW-1:0] b, input logic [DW-1:0] p,
                          input logic [DW-1:0] t, input logic [DW-1:0] h);
      stage[i*4+0] = b; stage[i*4+1] = p; stage[i*4+2] = t; stage[i*4+3] = h;
   endtask

   function automatic logic [DW-1:0] rnd16();
      case ($urandom_range(0, 3))
         0:       return DW'($urandom);
         1:       return 16'h7F00 + DW'($urandom_range(0, 255));
         2:       return 16'h8000 + DW'($urandom_range(0, 255));
         default: return DW'($urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      int d0, s0;
      logic [DW-1:0] savedPot;
      bus.start_i = 1'b0;
      for (int i = 0; i < MS; i++) stage[i] = '0;
      tick(3);
      loadStage();
      rst_n = 1'b1;
      tick(2);

      // All bias 1, pot 0, th 5: nothing fires, done 21 cycles after start.
      for (int i = 0; i < N; i++) setNurn(i, 16'd1, 16'd0, 16'd5, 16'h1234);
      loadStage();
      s0 = spikeCount;
      launch(0);
      tick(doneAt - 1);
      settleAndCheckMem();
      for (int i = 0; i < N; i++) check("t1_pot_is_1", 64'(mem[i*4+1]), 64'(16'd1));
      check("t1_done_cycle", 64'(doneOff), 64'(21));
      check("t1_no_spike", 64'(spikeCount - s0), 64'(0));

      // Neuron 2 reaches threshold exactly.
      for (int i = 0; i < N; i++) setNurn(i, 16'd1, 16'd0, 16'd5, 16'hABCD);
      stage[2*4+1] = 16'd4;
      loadStage();
      s0 = spikeCount;
      launch(0);
      tick(doneAt - 1);
      settleAndCheckMem();
      check("t2_done_cycle", 64'(doneOff), 64'(22));
      check("t2_spike_id", 64'(lastSpikeId), 64'(2));
      check("t2_spike_count", 64'(spikeCount - s0), 64'(1));
      check("t2_pot2_cleared", 64'(mem[9]), 64'(0));
      check("t2_hist2_cleared", 64'(mem[11]), 64'(0));
      check("t2_hist1_kept", 64'(mem[7]), 64'(16'hABCD));

      // Saturation at both rails.
      setNurn(0, 16'h0100, 16'h7FF0, 16'h7FFF, 16'h5555);
      setNurn(1, 16'hFF00, 16'h8010, 16'h0000, 16'h5555);
      setNurn(2, 16'h0000, 16'h0000, 16'h7FFF, 16'h5555);
      setNurn(3, 16'h0000, 16'h0000, 16'h7FFF, 16'h5555);
      loadStage();
      s0 = spikeCount;
      launch(0);
      tick(doneAt - 1);
      settleAndCheckMem();
      check("t3_pos_sat_fire_pot", 64'(mem[1]), 64'(0));
      check("t3_neg_sat_pot", 64'(mem[5]), 64'(16'h8000));
      check("t3_spike_count", 64'(spikeCount - s0), 64'(1));
      check("t3_spike_id", 64'(lastSpikeId), 64'(0));

      // Start while busy is ignored; start on done launches a second sweep.
      for (int i = 0; i < N; i++) setNurn(i, rnd16(), rnd16(), rnd16(), rnd16());
      loadStage();
      d0 = doneCount;
      launch(0);
      tick(6);
      bus.start_i = 1'b1;
      tick(1);
      bus.start_i = 1'b0;
      tick(doneAt - 8);
      launch(1);
      tick(doneAt - 1);
      settleAndCheckMem();
      check("t4_done_count", 64'(doneCount - d0), 64'(2));

      // Reset during WR_POT of neuron 1 aborts the sweep silently.
      for (int i = 0; i < N; i++) setNurn(i, 16'd1, rnd16(), 16'h7FFF, rnd16());
      stage[0*4+1] = 16'd0;
      stage[1*4+1] = 16'd100;
      loadStage();
      d0 = doneCount;
      s0 = spikeCount;
      savedPot = mem[5];
      launch(0);
      tick(9);
      rst_n  = 1'b0;
      active = 1'b0;
      tick(3);
      check("t5_no_pot1_write", 64'(mem[5]), 64'(savedPot));
      check("t5_no_done", 64'(doneCount - d0), 64'(0));
      check("t5_no_spike", 64'(spikeCount - s0), 64'(0));
      rst_n = 1'b1;
      tick(2);
      launch(0);
      tick(doneAt - 1);
      settleAndCheckMem();
      check("t5_done_after_restart", 64'(doneCount - d0), 64'(1));

      // Randomised sweeps biased toward the saturation rails.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) setNurn(i, rnd16(), rnd16(), rnd16(), rnd16());
         loadStage();
         launch(0);
         tick(doneAt - 1);
         settleAndCheckMem();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
